// File: rtl/rr_arb_dreg.sv
// N-to-1 round-robin arbiter feeding one registered valid/ready output stage.
// The winning channel index is carried in the output MSBs; optional grant locking.
module rr_arb_dreg #(
   parameter  int NUM   = 4,
   parameter  int DIN   = 16,
   parameter  int LOCK  = 0,
   localparam int SEL_W = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM-1:0]       din_valid,
   output logic [NUM-1:0]       din_ready,
   input  logic [NUM*DIN-1:0]   din_data,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DIN+SEL_W-1:0] dout_data
);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   state_t               r_state;
   logic [SEL_W-1:0]     r_lch;
   logic [SEL_W-1:0]     r_ptr;
   logic                 r_dout_valid;
   logic [DIN+SEL_W-1:0] r_dout_data;

   logic [SEL_W-1:0]     w_rr;
   logic [SEL_W-1:0]     w_gnt;
   logic [SEL_W-1:0]     w_nxt;
   logic [DIN-1:0]       w_pay;
   logic                 w_reg_ready;
   logic                 w_locked;
   logic                 w_gvld;
   logic                 w_xfer;
   logic                 w_eot;

   assign w_reg_ready = ~r_dout_valid | dout_ready;
   assign w_locked    = (LOCK != 0) && (r_state == S_LOCKED);

   // rotating scan starting at r_ptr; index wraps without a modulo
   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      w_rr  = '0;
      for (int k = 0; k < NUM; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NUM) j = j - NUM;
         if (!found && din_valid[j]) begin
            w_rr  = SEL_W'(j);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      w_gnt     = w_locked ? r_lch : w_rr;
      w_gvld    = din_valid[w_gnt];
      w_pay     = din_data[int'(w_gnt)*DIN +: DIN];
      w_eot     = w_pay[DIN-1];
      w_xfer    = ~rst & w_reg_ready & w_gvld;
      w_nxt     = (int'(w_gnt) == NUM-1) ? '0 : w_gnt + 1'b1;
      din_ready = '0;
      if (w_xfer) din_ready[w_gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout_valid <= 1'b0;
         r_ptr        <= '0;
         r_lch        <= '0;
         r_state      <= S_IDLE;
      end else begin
         if (w_reg_ready) r_dout_valid <= w_gvld;
         if (w_xfer) begin
            r_ptr <= w_nxt;
            if (LOCK != 0) begin
               unique case (r_state)
                  S_IDLE: begin
                     if (!w_eot) begin
                        r_state <= S_LOCKED;
                        r_lch   <= w_gnt;
                     end
                  end
                  S_LOCKED: begin
                     if (w_eot) r_state <= S_IDLE;
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end
      end
   end

   // payload is not reset; it is qualified by dout_valid
   always_ff @(posedge clk) begin
      if (w_reg_ready) r_dout_data <= {w_gnt, w_pay};
   end

   assign dout_valid = r_dout_valid;
   assign dout_data  = r_dout_data;

endmodule

// File: tb/tb_rr_arb_dreg.sv
// Directed bench for rr_arb_dreg: rotation, wrap, stall, lock and reset cases.
// Three instances: NUM=4 plain, NUM=4 locking, NUM=3 plain.
module tb_rr_arb_dreg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  a_vld, a_rdy;
   logic [63:0] a_dat;
   logic        a_ov, a_ordy;
   logic [17:0] a_od;

   logic [3:0]  b_vld, b_rdy;
   logic [63:0] b_dat;
   logic        b_ov, b_ordy;
   logic [17:0] b_od;

   logic [2:0]  c_vld, c_rdy;
   logic [47:0] c_dat;
   logic        c_ov, c_ordy;
   logic [17:0] c_od;

   int n_cmp = 0;
   int n_err = 0;

   rr_arb_dreg #(.NUM(4), .DIN(16), .LOCK(0)) u_a (
      .clk(clk), .rst(rst),
      .din_valid(a_vld), .din_ready(a_rdy), .din_data(a_dat),
      .dout_valid(a_ov), .dout_ready(a_ordy), .dout_data(a_od)
   );

   rr_arb_dreg #(.NUM(4), .DIN(16), .LOCK(1)) u_b (
      .clk(clk), .rst(rst),
      .din_valid(b_vld), .din_ready(b_rdy), .din_data(b_dat),
      .dout_valid(b_ov), .dout_ready(b_ordy), .dout_data(b_od)
   );

   rr_arb_dreg #(.NUM(3), .DIN(16), .LOCK(0)) u_c (
      .clk(clk), .rst(rst),
      .din_valid(c_vld), .din_ready(c_rdy), .din_data(c_dat),
      .dout_valid(c_ov), .dout_ready(c_ordy), .dout_data(c_od)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ea(input int s);
      logic [17:0] v;
      v = {2'(s), 16'h0A00 | 16'(s)};
      return 32'(v);
   endfunction

   function automatic logic [31:0] ec(input int s);
      logic [17:0] v;
      v = {2'(s), 16'h0C00 | 16'(s)};
      return 32'(v);
   endfunction

   function automatic logic [15:0] pb(input int i, input logic e);
      return {e, 3'b000, 12'hB00 | 12'(i)};
   endfunction

   function automatic logic [31:0] eb(input int s, input logic e);
      logic [17:0] v;
      v = {2'(s), pb(s, e)};
      return 32'(v);
   endfunction

   task automatic set_b(input logic [3:0] eot);
      b_dat = {pb(3, eot[3]), pb(2, eot[2]), pb(1, eot[1]), pb(0, eot[0])};
   endtask

   initial begin
      rst    = 1'b1;
      a_vld  = 4'hF;
      a_ordy = 1'b1;
      a_dat  = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
      b_vld  = 4'h0;
      b_ordy = 1'b1;
      set_b(4'hF);
      c_vld  = 3'b111;
      c_ordy = 1'b1;
      c_dat  = {16'h0C02, 16'h0C01, 16'h0C00};
      step;
      step;
      check("rst_ov", 32'(a_ov), 0);
      check("rst_rdy", 32'(a_rdy), 0);
      check("rst_b_ov", 32'(b_ov), 0);
      rst = 1'b0;
      #1;

      // all valid: rotate 0,1,2,3,... and 0,1,2,... on NUM=3
      for (int k = 0; k < 6; k++) begin
         check("t1_rdy", 32'(a_rdy), 32'(1 << (k % 4)));
         check("t6_rdy", 32'(c_rdy), 32'(1 << (k % 3)));
         step;
         check("t1_ov", 32'(a_ov), 1);
         check("t1_od", 32'(a_od), ea(k % 4));
         check("t6_ov", 32'(c_ov), 1);
         check("t6_od", 32'(c_od), ec(k % 3));
      end
      c_vld = 3'b000;

      // ptr=2: ch2 alone, then ch0+ch2 wraps to ch0, then ch2
      a_vld = 4'b0100;
      #1;
      check("t2_rdy_a", 32'(a_rdy), 32'h4);
      step;
      check("t2_od_a", 32'(a_od), ea(2));
      a_vld = 4'b0101;
      #1;
      check("t2_rdy_b", 32'(a_rdy), 32'h1);
      step;
      check("t2_od_b", 32'(a_od), ea(0));
      check("t2_rdy_c", 32'(a_rdy), 32'h4);
      step;
      check("t2_od_c", 32'(a_od), ea(2));

      // stall with output full
      a_vld  = 4'hF;
      a_ordy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_rdy", 32'(a_rdy), 0);
         step;
         check("t3_ov", 32'(a_ov), 1);
         check("t3_od", 32'(a_od), ea(2));
      end
      a_ordy = 1'b1;
      #1;
      check("t3_rdy_r", 32'(a_rdy), 32'h8);
      step;
      check("t3_od_r3", 32'(a_od), ea(3));
      check("t3_rdy_r0", 32'(a_rdy), 32'h1);
      step;
      check("t3_od_r0", 32'(a_od), ea(0));
      a_vld = 4'h0;
      #1;
      check("t3_rdy_0", 32'(a_rdy), 0);
      step;
      check("t3_ov_0", 32'(a_ov), 0);

      // lock: single-beat ch0 moves ptr to 1
      b_vld = 4'b0001;
      set_b(4'hF);
      #1;
      check("t4_rdy0", 32'(b_rdy), 32'h1);
      step;
      check("t4_od0", 32'(b_od), eb(0, 1'b1));
      b_vld = 4'b1011;
      set_b(4'b1101);
      #1;
      check("t4_rdy1", 32'(b_rdy), 32'h2);
      step;
      check("t4_od1", 32'(b_od), eb(1, 1'b0));
      check("t4_rdy2", 32'(b_rdy), 32'h2);
      step;
      check("t4_od2", 32'(b_od), eb(1, 1'b0));
      b_vld = 4'b1001;
      #1;
      check("t4_rdy_idle", 32'(b_rdy), 0);
      step;
      check("t4_ov_idle", 32'(b_ov), 0);
      b_vld = 4'b1011;
      set_b(4'hF);
      #1;
      check("t4_rdy3", 32'(b_rdy), 32'h2);
      step;
      check("t4_od3", 32'(b_od), eb(1, 1'b1));
      b_vld = 4'b1001;
      #1;
      check("t4_rdy_ch3", 32'(b_rdy), 32'h8);
      step;
      check("t4_od_ch3", 32'(b_od), eb(3, 1'b1));

      // lock on ch2, then reset while output holds a beat
      b_vld = 4'b0100;
      set_b(4'h0);
      #1;
      check("t5_rdy_l", 32'(b_rdy), 32'h4);
      step;
      check("t5_ov_l", 32'(b_ov), 1);
      check("t5_od_l", 32'(b_od), eb(2, 1'b0));
      rst   = 1'b1;
      b_vld = 4'hF;
      #1;
      check("t5_rdy_rst", 32'(b_rdy), 0);
      step;
      check("t5_ov_rst", 32'(b_ov), 0);
      rst = 1'b0;
      set_b(4'hF);
      #1;
      check("t5_rdy0", 32'(b_rdy), 32'h1);
      step;
      check("t5_od0", 32'(b_od), eb(0, 1'b1));
      check("t5_rdy1", 32'(b_rdy), 32'h2);
      step;
      check("t5_od1", 32'(b_od), eb(1, 1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
